// File: rtl/nav_command_sequencer.sv
// nav_command_sequencer
// Per-axis pilot command front end. Accepts commands over valid/ready, tracks
// the flight mode (velocity mux select), sequences position-zero and one-cycle
// warp jumps (position mux select) and enforces a post-warp cooldown.
//
// Optional feature macro: STEALTH_WARP_LOCK_EN
//   defined   -> WARP is rejected while the stealth mode is selected
//   undefined -> WARP is permitted in any mode, subject only to cooldown
//
// Parameters:
//   COOLDOWN_CYCLES : cycles after a warp during which a new warp is rejected (0 = none)
//   CNT_W           : cooldown counter width, must hold COOLDOWN_CYCLES
//
// Ports:
//   clk            : system clock, rising edge
//   reset          : synchronous active-high reset
//   cmd_valid      : command present
//   cmd_code [2:0] : 0 RESET, 1 ATTACK, 2 DEFENSE, 3 STEALTH, 4 WARP, 5-7 illegal
//   cmd_ready      : command can be accepted this cycle
//   cmd_err        : one-cycle pulse after an accepted command was rejected
//   mode_sel [3:0] : one-hot velocity select (reset/attack/defense/stealth)
//   pos_sel  [3:0] : one-hot position select (zero/integrate/warp)
//   warp_active    : high in the warp cycle
//   cooldown_busy  : cooldown counter nonzero
module nav_command_sequencer #(
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       cmd_err,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic       warp_active,
  output logic       cooldown_busy
);

  localparam logic [2:0] CMD_RESET   = 3'd0;
  localparam logic [2:0] CMD_ATTACK  = 3'd1;
  localparam logic [2:0] CMD_DEFENSE = 3'd2;
  localparam logic [2:0] CMD_STEALTH = 3'd3;
  localparam logic [2:0] CMD_WARP    = 3'd4;

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_SEL_ZERO = 4'b0001;
  localparam logic [3:0] POS_SEL_INT  = 4'b0010;
  localparam logic [3:0] POS_SEL_WARP = 4'b0100;

  typedef enum logic [1:0] {
    POS_ZERO = 2'd0,
    RUN      = 2'd1,
    WARP     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       mode_nxt;
  logic [3:0]       pos_nxt;
  logic             err_nxt;
  logic             accept;
  logic             warp_blocked;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= POS_ZERO;
      cnt           <= '0;
      mode_sel      <= MODE_RESET;
      pos_sel       <= POS_SEL_ZERO;
      warp_active   <= 1'b0;
      cmd_ready     <= 1'b1;
      cmd_err       <= 1'b0;
      cooldown_busy <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      mode_sel      <= mode_nxt;
      pos_sel       <= pos_nxt;
      warp_active   <= (state_nxt == WARP);
      cmd_ready     <= (state_nxt != WARP);
      cmd_err       <= err_nxt;
      cooldown_busy <= (cnt_nxt != '0);
    end
  end

  // Warp permission: cooldown, plus optional stealth lock
`ifdef STEALTH_WARP_LOCK_EN
  assign warp_blocked = (cnt != '0) || (mode_sel == MODE_STEALTH);
`else
  assign warp_blocked = (cnt != '0);
`endif

  assign accept = cmd_valid && cmd_ready;

  // Next state, mode, cooldown and error
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_sel;
    err_nxt   = 1'b0;

    // Autonomous sequencing; commands below may override it
    case (state)
      POS_ZERO: state_nxt = RUN;
      RUN: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
      end
      WARP: begin
        state_nxt = RUN;
        cnt_nxt   = CNT_W'(COOLDOWN_CYCLES);
      end
      default: state_nxt = POS_ZERO;
    endcase

    if (accept) begin
      case (cmd_code)
        CMD_RESET: begin
          mode_nxt  = MODE_RESET;
          state_nxt = POS_ZERO;
          cnt_nxt   = '0;
        end
        CMD_ATTACK:  mode_nxt = MODE_ATTACK;
        CMD_DEFENSE: mode_nxt = MODE_DEFENSE;
        CMD_STEALTH: mode_nxt = MODE_STEALTH;
        CMD_WARP: begin
          // A warp accepted in POS_ZERO still follows the zero cycle
          if (warp_blocked) err_nxt = 1'b1;
          else              state_nxt = WARP;
        end
        default: err_nxt = 1'b1;
      endcase
    end

    case (state_nxt)
      POS_ZERO: pos_nxt = POS_SEL_ZERO;
      RUN:      pos_nxt = POS_SEL_INT;
      WARP:     pos_nxt = POS_SEL_WARP;
      default:  pos_nxt = POS_SEL_ZERO;
    endcase
  end

endmodule

// File: tb/tb_nav_command_sequencer.sv
// Testbench for nav_command_sequencer (COOLDOWN_CYCLES=3). A behavioural
// reference model predicts each cycle's outputs, pushes them to a scoreboard
// queue when stimulus is driven, and they are popped and compared after the edge.
module tb_nav_command_sequencer;

  localparam int unsigned CD = 3;

  typedef struct packed {
    logic [3:0] mode_sel;
    logic [3:0] pos_sel;
    logic       warp_active;
    logic       cmd_ready;
    logic       cmd_err;
    logic       cooldown_busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       cmd_err;
  logic [3:0] mode_sel;
  logic [3:0] pos_sel;
  logic       warp_active;
  logic       cooldown_busy;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // Reference model state: 0 zero, 1 run, 2 warp; mode index 0..3
  int m_state = 0;
  int m_mode  = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  nav_command_sequencer #(.COOLDOWN_CYCLES(CD), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .cmd_err      (cmd_err),
    .mode_sel     (mode_sel),
    .pos_sel      (pos_sel),
    .warp_active  (warp_active),
    .cooldown_busy(cooldown_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge
  task automatic step(input logic r, input logic v, input logic [2:0] code);
    int   ns, nm, nc;
    logic err;
    bit   lock;
    exp_t e;
    exp_t g;
    @(negedge clk);
    reset     = r;
    cmd_valid = v;
    cmd_code  = code;
`ifdef STEALTH_WARP_LOCK_EN
    lock = 1'b1;
`else
    lock = 1'b0;
`endif
    if (r) begin
      ns = 0; nm = 0; nc = 0; err = 1'b0;
    end else begin
      nm  = m_mode;
      err = 1'b0;
      if (m_state == 2)      begin ns = 1; nc = CD; end
      else if (m_state == 1) begin ns = 1; nc = (m_cnt > 0) ? m_cnt - 1 : 0; end
      else                   begin ns = 1; nc = m_cnt; end
      if (v && m_state != 2) begin
        if (code == 3'd0) begin
          nm = 0; ns = 0; nc = 0;
        end else if (code >= 3'd1 && code <= 3'd3) begin
          nm = int'(code);
        end else if (code == 3'd4) begin
          if (m_cnt != 0 || (lock && m_mode == 3)) err = 1'b1;
          else ns = 2;
        end else begin
          err = 1'b1;
        end
      end
    end
    e.mode_sel      = 4'(1 << nm);
    e.pos_sel       = 4'(1 << ns);
    e.warp_active   = (ns == 2);
    e.cmd_ready     = (ns != 2);
    e.cmd_err       = err;
    e.cooldown_busy = (nc != 0);
    sb.push_back(e);
    m_state = ns; m_mode = nm; m_cnt = nc;

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("mode_sel",      32'(mode_sel),      32'(g.mode_sel));
      check("pos_sel",       32'(pos_sel),       32'(g.pos_sel));
      check("warp_active",   32'(warp_active),   32'(g.warp_active));
      check("cmd_ready",     32'(cmd_ready),     32'(g.cmd_ready));
      check("cmd_err",       32'(cmd_err),       32'(g.cmd_err));
      check("cooldown_busy", 32'(cooldown_busy), 32'(g.cooldown_busy));
      check("pos_onehot",    32'($onehot(pos_sel)), 32'd1);
      check("mode_onehot",   32'($onehot(mode_sel)), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    logic       rv;
    logic [2:0] rc;
    logic       pend;
    reset = 1'b1; cmd_valid = 1'b0; cmd_code = 3'd0;

    // Reset for two cycles, then zero cycle, then run
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    idle(2);

    // ATTACK then DEFENSE three cycles later
    step(1'b0, 1'b1, 3'd1);
    idle(2);
    step(1'b0, 1'b1, 3'd2);
    step(1'b0, 1'b1, 3'd2);
    idle(1);

    // Warp, then a warp attempt during cooldown, drain cooldown
    step(1'b0, 1'b1, 3'd4);
    idle(2);
    step(1'b0, 1'b1, 3'd4);
    idle(4);

    // Illegal code
    step(1'b0, 1'b1, 3'd6);
    idle(1);

    // RESET command at counter=2, warp granted from POS_ZERO
    step(1'b0, 1'b1, 3'd4);
    idle(2);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd4);
    idle(5);

    // Command held while not ready is taken afterwards without error
    step(1'b0, 1'b1, 3'd4);
    step(1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b1, 3'd3);
    idle(5);

    // Stealth then warp (lock-dependent)
    step(1'b0, 1'b1, 3'd4);
    idle(5);

    // Reset input dominates a warp command
    step(1'b0, 1'b1, 3'd1);
    step(1'b1, 1'b1, 3'd4);
    idle(2);

    // Random traffic, holding any command that was not accepted
    pend = 1'b0; rc = 3'd0;
    for (int i = 0; i < 300; i++) begin
      if (!pend) begin
        rv = 1'($urandom_range(0, 1));
        rc = 3'($urandom_range(0, 7));
      end else begin
        rv = 1'b1;
      end
      pend = rv && (m_state == 2);
      step(1'b0, rv, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
